reg_writeback: RTL

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/wb_pkg.sv | 15 +
 rtl/ld_queue.sv | 74 +++++++
 rtl/reg_writeback.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths, queue depth and load-tracker state type for the writeback stage.
package wb_pkg;

  localparam int W         = 8;
  localparam int A         = 2;
  localparam int NREG      = 2 ** A;
  localparam int LDQ_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ld_state_t;

endpackage

// File: rtl/ld_queue.sv
// In-order destination queue for outstanding loads; the head is the next register to be written.
module ld_queue #(
  parameter int A = wb_pkg::A
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic [A-1:0]      push_addr,
  output logic [A-1:0]      head,
  output wb_pkg::ld_state_t state,
  output logic [2**A-1:0]   busy
);
  import wb_pkg::*;

  ld_state_t    state_q, state_d;
  logic [A-1:0] entry_q [LDQ_DEPTH];
  logic [A-1:0] entry_d [LDQ_DEPTH];

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          entry_d[0] = push_addr;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          entry_d[0] = push_addr;
        end else if (push) begin
          entry_d[1] = push_addr;
          state_d    = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          entry_d[0] = entry_q[1];
          if (push) begin
            entry_d[1] = push_addr;
          end else begin
            state_d = ONE;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= EMPTY;
      entry_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end

  // A register queued twice stays busy while any live entry still names it.
  always_comb begin
    busy = '0;
    if (state_q != EMPTY) busy[entry_q[0]] = 1'b1;
    if (state_q == FULL)  busy[entry_q[1]] = 1'b1;
  end

  assign head  = entry_q[0];
  assign state = state_q;

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: load returns beat ALU results to a registered write port.
// Define REG_WB_SKID_EN to park an ALU result that collides with a load return in a skid entry.
module reg_writeback #(
  parameter int W = wb_pkg::W,
  parameter int A = wb_pkg::A
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AluValid,
  input  logic [A-1:0]      AluAddr,
  input  logic [W-1:0]      AluData,
  input  logic              LdIssue,
  input  logic [A-1:0]      LdAddr,
  input  logic              MemValid,
  input  logic [W-1:0]      MemData,
  output logic              WriteEn,
  output logic [A-1:0]      Waddr,
  output logic [W-1:0]      DataIn,
  output logic [2**A-1:0]   Busy,
  output logic              Stall,
  output logic              Err
);
  import wb_pkg::*;

  ld_state_t    ld_state;
  logic [A-1:0] ld_head;
  logic         q_full, q_empty, pop, push, alu_accept;

  logic         we_q, we_d;
  logic [A-1:0] waddr_q, waddr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic         err_q, err_d;

`ifdef REG_WB_SKID_EN
  logic         skid_valid_q, skid_valid_d;
  logic [A-1:0] skid_addr_q, skid_addr_d;
  logic [W-1:0] skid_data_q, skid_data_d;
`endif

  ld_queue #(.A(A)) u_ld_queue (
    .Clk      (Clk),
    .Reset    (Reset),
    .push     (push),
    .pop      (pop),
    .push_addr(LdAddr),
    .head     (ld_head),
    .state    (ld_state),
    .busy     (Busy)
  );

  assign q_full  = (ld_state == FULL);
  assign q_empty = (ld_state == EMPTY);
  assign pop     = MemValid & ~q_empty;
  assign push    = LdIssue & (~q_full | pop);

`ifdef REG_WB_SKID_EN
  assign Stall = q_full | skid_valid_q | (AluValid & Busy[AluAddr]);
`else
  assign Stall = q_full | (AluValid & Busy[AluAddr]) | (AluValid & MemValid);
`endif

  assign alu_accept = AluValid & ~Stall;

  // Write-port priority: load return, then parked skid result, then a fresh ALU result.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef REG_WB_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;
    if (pop && alu_accept) begin
      skid_valid_d = 1'b1;
      skid_addr_d  = AluAddr;
      skid_data_d  = AluData;
    end else if (!pop && skid_valid_q) begin
      skid_valid_d = 1'b0;
    end
`endif
    if (pop) begin
      we_d    = 1'b1;
      waddr_d = ld_head;
      wdata_d = MemData;
    end
`ifdef REG_WB_SKID_EN
    else if (skid_valid_q) begin
      we_d    = 1'b1;
      waddr_d = skid_addr_q;
      wdata_d = skid_data_q;
    end
`endif
    else if (alu_accept) begin
      we_d    = 1'b1;
      waddr_d = AluAddr;
      wdata_d = AluData;
    end
  end

  assign err_d = err_q | (LdIssue & q_full & ~pop) | (MemValid & q_empty);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

`ifdef REG_WB_SKID_EN
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
    end
  end
`endif

  assign WriteEn = we_q;
  assign Waddr   = waddr_q;
  assign DataIn  = wdata_q;
  assign Err     = err_q;

endmodule
